// File: rtl/encap_tunnel_lookup_pkg.sv
// Shared widths, bucket field offsets and lookup FSM state encodings for the tunnel lookup.
// Bucket layout is {valid, key, value_ptr}, MSB first.
package encap_tunnel_lookup_pkg;

    localparam int DEF_DEPTH_NBITS       = 10;
    localparam int DEF_KEY_NBITS         = 24;
    localparam int DEF_VALUE_DEPTH_NBITS = 10;
    localparam int DEF_VALUE_NBITS       = 288;
    localparam int DEF_CNT_NBITS         = 32;
    localparam int DEF_BUCKET_NBITS      = 1 + DEF_KEY_NBITS + DEF_VALUE_DEPTH_NBITS;

    localparam int BKT_PTR_LSB   = 0;
    localparam int BKT_KEY_LSB   = DEF_VALUE_DEPTH_NBITS;
    localparam int BKT_VALID_BIT = DEF_KEY_NBITS + DEF_VALUE_DEPTH_NBITS;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HASH_WAIT = 2'd1,
        ST_VAL_WAIT  = 2'd2,
        ST_RSP       = 2'd3
    } lkup_state_e;

endpackage

// File: rtl/tunnel_hash_fold.sv
// Combinational XOR-fold of a key into OUT_NBITS chunks, last chunk zero-extended.
// Optionally bit-reverses the key before folding; zero latency, no flow control.
module tunnel_hash_fold #(
    parameter int IN_NBITS  = 24,
    parameter int OUT_NBITS = 10,
    parameter bit REVERSE   = 1'b0
) (
    input  logic [IN_NBITS-1:0]  din,
    output logic [OUT_NBITS-1:0] dout
);

    localparam int NCHUNK    = (IN_NBITS + OUT_NBITS - 1) / OUT_NBITS;
    localparam int PAD_NBITS = NCHUNK * OUT_NBITS;

    logic [IN_NBITS-1:0]  src;
    logic [PAD_NBITS-1:0] padded;

    always_comb begin
        src = din;
        if (REVERSE) begin
            for (int i = 0; i < IN_NBITS; i++) begin
                src[i] = din[IN_NBITS-1-i];
            end
        end
        padded = PAD_NBITS'(src);
        dout   = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            dout = dout ^ padded[c*OUT_NBITS +: OUT_NBITS];
        end
    end

endmodule

// File: rtl/encap_tunnel_lookup.sv
// Tunnel key lookup: dual-bucket hash read, key compare, value fetch on hit; one lookup in flight.
// Latency 1 + hash ack + 1 (miss), plus value ack + 1 on hit; result held until rsp_rdy.
module encap_tunnel_lookup
    import encap_tunnel_lookup_pkg::*;
#(
    parameter int DEPTH_NBITS       = DEF_DEPTH_NBITS,
    parameter int KEY_NBITS         = DEF_KEY_NBITS,
    parameter int VALUE_DEPTH_NBITS = DEF_VALUE_DEPTH_NBITS,
    parameter int BUCKET_NBITS      = 1 + KEY_NBITS + VALUE_DEPTH_NBITS,
    parameter int VALUE_NBITS       = DEF_VALUE_NBITS,
    parameter int CNT_NBITS         = DEF_CNT_NBITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lkup_req,
    input  logic [KEY_NBITS-1:0]         lkup_key,
    output logic                         lkup_rdy,
    output logic                         tunnel_hash_table0_rd,
    output logic [DEPTH_NBITS-1:0]       tunnel_hash_table0_raddr,
    output logic                         tunnel_hash_table1_rd,
    output logic [DEPTH_NBITS-1:0]       tunnel_hash_table1_raddr,
    input  logic                         tunnel_hash_table0_ack,
    input  logic [BUCKET_NBITS-1:0]      tunnel_hash_table0_rdata,
    input  logic                         tunnel_hash_table1_ack,
    input  logic [BUCKET_NBITS-1:0]      tunnel_hash_table1_rdata,
    output logic                         tunnel_value_rd,
    output logic [VALUE_DEPTH_NBITS-1:0] tunnel_value_raddr,
    input  logic                         tunnel_value_ack,
    input  logic [VALUE_NBITS-1:0]       tunnel_value_rdata,
    output logic                         rsp_valid,
    input  logic                         rsp_rdy,
    output logic                         rsp_hit,
    output logic [VALUE_NBITS-1:0]       rsp_value,
    output logic [CNT_NBITS-1:0]         hit_cnt,
    output logic [CNT_NBITS-1:0]         miss_cnt
);

    localparam int PTR_LSB   = 0;
    localparam int KEY_LSB   = VALUE_DEPTH_NBITS;
    localparam int VALID_BIT = KEY_NBITS + VALUE_DEPTH_NBITS;
    localparam logic [CNT_NBITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_NBITS-1:0] CNT_ONE = {{(CNT_NBITS-1){1'b0}}, 1'b1};

    lkup_state_e                  state_q, state_d;
    logic [KEY_NBITS-1:0]         key_q, key_d;
    logic                         hash_rd_q, hash_rd_d;
    logic [DEPTH_NBITS-1:0]       raddr0_q, raddr0_d, raddr1_q, raddr1_d;
    logic                         got0_q, got0_d, got1_q, got1_d;
    logic [BUCKET_NBITS-1:0]      bkt0_q, bkt0_d, bkt1_q, bkt1_d;
    logic                         val_rd_q, val_rd_d;
    logic [VALUE_DEPTH_NBITS-1:0] val_raddr_q, val_raddr_d;
    logic                         rsp_hit_q, rsp_hit_d;
    logic [VALUE_NBITS-1:0]       rsp_value_q, rsp_value_d;
    logic [CNT_NBITS-1:0]         hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [DEPTH_NBITS-1:0]       h0, h1;
    logic                         m0, m1;

    tunnel_hash_fold #(.IN_NBITS(KEY_NBITS), .OUT_NBITS(DEPTH_NBITS), .REVERSE(1'b0))
        u_fold_h0 (.din(lkup_key), .dout(h0));
    tunnel_hash_fold #(.IN_NBITS(KEY_NBITS), .OUT_NBITS(DEPTH_NBITS), .REVERSE(1'b1))
        u_fold_h1 (.din(lkup_key), .dout(h1));

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        hash_rd_d   = 1'b0;
        raddr0_d    = raddr0_q;
        raddr1_d    = raddr1_q;
        got0_d      = got0_q;
        got1_d      = got1_q;
        bkt0_d      = bkt0_q;
        bkt1_d      = bkt1_q;
        val_rd_d    = 1'b0;
        val_raddr_d = val_raddr_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_value_d = rsp_value_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        m0          = 1'b0;
        m1          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lkup_req) begin
                    key_d     = lkup_key;
                    raddr0_d  = h0;
                    raddr1_d  = h1;
                    hash_rd_d = 1'b1;
                    got0_d    = 1'b0;
                    got1_d    = 1'b0;
                    state_d   = ST_HASH_WAIT;
                end
            end
            ST_HASH_WAIT: begin
                // Only the first ack per table is captured; repeats leave the bucket untouched.
                if (tunnel_hash_table0_ack && !got0_q) begin
                    got0_d = 1'b1;
                    bkt0_d = tunnel_hash_table0_rdata;
                end
                if (tunnel_hash_table1_ack && !got1_q) begin
                    got1_d = 1'b1;
                    bkt1_d = tunnel_hash_table1_rdata;
                end
                m0 = bkt0_d[VALID_BIT] && (bkt0_d[KEY_LSB +: KEY_NBITS] == key_q);
                m1 = bkt1_d[VALID_BIT] && (bkt1_d[KEY_LSB +: KEY_NBITS] == key_q);
                if (got0_d && got1_d) begin
                    if (m0) begin
                        val_rd_d    = 1'b1;
                        val_raddr_d = bkt0_d[PTR_LSB +: VALUE_DEPTH_NBITS];
                        state_d     = ST_VAL_WAIT;
                    end else if (m1) begin
                        val_rd_d    = 1'b1;
                        val_raddr_d = bkt1_d[PTR_LSB +: VALUE_DEPTH_NBITS];
                        state_d     = ST_VAL_WAIT;
                    end else begin
                        rsp_hit_d   = 1'b0;
                        rsp_value_d = '0;
                        state_d     = ST_RSP;
                    end
                end
            end
            ST_VAL_WAIT: begin
                if (tunnel_value_ack) begin
                    rsp_value_d = tunnel_value_rdata;
                    rsp_hit_d   = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_rdy) begin
                    if (rsp_hit_q) begin
                        hit_cnt_d = (hit_cnt_q == CNT_MAX) ? hit_cnt_q : hit_cnt_q + CNT_ONE;
                    end else begin
                        miss_cnt_d = (miss_cnt_q == CNT_MAX) ? miss_cnt_q : miss_cnt_q + CNT_ONE;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            hash_rd_q   <= 1'b0;
            raddr0_q    <= '0;
            raddr1_q    <= '0;
            got0_q      <= 1'b0;
            got1_q      <= 1'b0;
            bkt0_q      <= '0;
            bkt1_q      <= '0;
            val_rd_q    <= 1'b0;
            val_raddr_q <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_value_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            hash_rd_q   <= hash_rd_d;
            raddr0_q    <= raddr0_d;
            raddr1_q    <= raddr1_d;
            got0_q      <= got0_d;
            got1_q      <= got1_d;
            bkt0_q      <= bkt0_d;
            bkt1_q      <= bkt1_d;
            val_rd_q    <= val_rd_d;
            val_raddr_q <= val_raddr_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_value_q <= rsp_value_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign lkup_rdy                 = (state_q == ST_IDLE);
    assign rsp_valid                = (state_q == ST_RSP);
    assign tunnel_hash_table0_rd    = hash_rd_q;
    assign tunnel_hash_table1_rd    = hash_rd_q;
    assign tunnel_hash_table0_raddr = raddr0_q;
    assign tunnel_hash_table1_raddr = raddr1_q;
    assign tunnel_value_rd          = val_rd_q;
    assign tunnel_value_raddr       = val_raddr_q;
    assign rsp_hit                  = rsp_hit_q;
    assign rsp_value                = rsp_value_q;
    assign hit_cnt                  = hit_cnt_q;
    assign miss_cnt                 = miss_cnt_q;

endmodule

// File: tb/tb_encap_tunnel_lookup.sv
// Directed bench for encap_tunnel_lookup; the bench plays all three memories by hand.
module tb_encap_tunnel_lookup;

    logic         clk = 1'b0;
    logic         rst;
    logic         lkup_req;
    logic [23:0]  lkup_key;
    logic         lkup_rdy;
    logic         hrd0, hrd1;
    logic [9:0]   hraddr0, hraddr1;
    logic         hack0, hack1;
    logic [34:0]  hdata0, hdata1;
    logic         vrd;
    logic [9:0]   vraddr;
    logic         vack;
    logic [287:0] vdata;
    logic         rsp_valid, rsp_rdy, rsp_hit;
    logic [287:0] rsp_value;
    logic [31:0]  hit_cnt, miss_cnt;

    int checks   = 0;
    int failures = 0;
    int val_rd_cnt  = 0;
    int hash_rd_cnt = 0;

    localparam logic [287:0] VAL_A = {{8{32'hABCD_EF01}}, 32'h1234_5678};
    localparam logic [287:0] VAL_B = {{8{32'h5A5A_0F0F}}, 32'hDEAD_BEEF};
    localparam logic [287:0] VAL_C = {{8{32'h0000_FFFF}}, 32'hC0FF_EE00};

    encap_tunnel_lookup dut (
        .clk(clk), .rst(rst),
        .lkup_req(lkup_req), .lkup_key(lkup_key), .lkup_rdy(lkup_rdy),
        .tunnel_hash_table0_rd(hrd0), .tunnel_hash_table0_raddr(hraddr0),
        .tunnel_hash_table1_rd(hrd1), .tunnel_hash_table1_raddr(hraddr1),
        .tunnel_hash_table0_ack(hack0), .tunnel_hash_table0_rdata(hdata0),
        .tunnel_hash_table1_ack(hack1), .tunnel_hash_table1_rdata(hdata1),
        .tunnel_value_rd(vrd), .tunnel_value_raddr(vraddr),
        .tunnel_value_ack(vack), .tunnel_value_rdata(vdata),
        .rsp_valid(rsp_valid), .rsp_rdy(rsp_rdy), .rsp_hit(rsp_hit), .rsp_value(rsp_value),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vrd)  val_rd_cnt  <= val_rd_cnt + 1;
        if (hrd0) hash_rd_cnt <= hash_rd_cnt + 1;
    end

    function automatic logic [34:0] mk(input logic v, input logic [23:0] k, input logic [9:0] p);
        return {v, k, p};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [23:0] k);
        lkup_req = 1'b1;
        lkup_key = k;
        tick();
        lkup_req = 1'b0;
    endtask

    task automatic ack_both(input logic [34:0] b0, input logic [34:0] b1);
        hack0 = 1'b1; hdata0 = b0;
        hack1 = 1'b1; hdata1 = b1;
        tick();
        hack0 = 1'b0; hack1 = 1'b0;
    endtask

    task automatic ack_value(input logic [287:0] v);
        vack = 1'b1; vdata = v;
        tick();
        vack = 1'b0;
    endtask

    task automatic handshake();
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_value !== '0) begin
            failures++; $display("FAIL reset_rsp: valid=%b hit=%b value_nz=%b exp 0", rsp_valid, rsp_hit, |rsp_value); end
        checks++; if (hrd0 !== 1'b0 || hrd1 !== 1'b0 || vrd !== 1'b0) begin
            failures++; $display("FAIL reset_strobes: %b%b%b exp 000", hrd0, hrd1, vrd); end
        checks++; if (hraddr0 !== 10'h0 || hraddr1 !== 10'h0 || vraddr !== 10'h0) begin
            failures++; $display("FAIL reset_raddr: %h %h %h exp 0", hraddr0, hraddr1, vraddr); end
        checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
            failures++; $display("FAIL reset_cnt: hit=%h miss=%h exp 0", hit_cnt, miss_cnt); end
        rst = 1'b0;
        tick();
        checks++; if (lkup_rdy !== 1'b1) begin
            failures++; $display("FAIL reset_rdy: got %b exp 1", lkup_rdy); end
    endtask

    task automatic test_table0_hit();
        issue(24'h000005);
        checks++; if (hrd0 !== 1'b1 || hrd1 !== 1'b1) begin
            failures++; $display("FAIL t0hit_hash_rd: got %b%b exp 11", hrd0, hrd1); end
        checks++; if (hraddr0 !== 10'h005) begin
            failures++; $display("FAIL t0hit_raddr0: got %h exp 005", hraddr0); end
        checks++; if (hraddr1 !== 10'h00A) begin
            failures++; $display("FAIL t0hit_raddr1: got %h exp 00a", hraddr1); end
        checks++; if (lkup_rdy !== 1'b0) begin
            failures++; $display("FAIL t0hit_busy_rdy: got %b exp 0", lkup_rdy); end
        tick();
        checks++; if (hrd0 !== 1'b0 || hrd1 !== 1'b0) begin
            failures++; $display("FAIL t0hit_rd_pulse: got %b%b exp 00", hrd0, hrd1); end
        ack_both(mk(1'b1, 24'h000005, 10'h123), mk(1'b0, 24'h000005, 10'h3FF));
        checks++; if (vrd !== 1'b1 || vraddr !== 10'h123) begin
            failures++; $display("FAIL t0hit_value_rd: rd=%b addr=%h exp 1/123", vrd, vraddr); end
        tick();
        checks++; if (vrd !== 1'b0 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL t0hit_val_wait: rd=%b valid=%b exp 0/0", vrd, rsp_valid); end
        ack_value(VAL_A);
        checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_value !== VAL_A) begin
            failures++; $display("FAIL t0hit_rsp: valid=%b hit=%b value=%h exp 1/1/%h", rsp_valid, rsp_hit, rsp_value[31:0], VAL_A[31:0]); end
        handshake();
        checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd0) begin
            failures++; $display("FAIL t0hit_cnt: hit=%0d miss=%0d exp 1/0", hit_cnt, miss_cnt); end
        checks++; if (lkup_rdy !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL t0hit_idle: rdy=%b valid=%b exp 1/0", lkup_rdy, rsp_valid); end
    endtask

    task automatic test_dual_match();
        issue(24'h000005);
        tick();
        ack_both(mk(1'b1, 24'h000005, 10'h010), mk(1'b1, 24'h000005, 10'h020));
        checks++; if (vrd !== 1'b1 || vraddr !== 10'h010) begin
            failures++; $display("FAIL dual_value_raddr: rd=%b addr=%h exp 1/010", vrd, vraddr); end
        ack_value(VAL_B);
        checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_value !== VAL_B) begin
            failures++; $display("FAIL dual_rsp: valid=%b hit=%b value=%h", rsp_valid, rsp_hit, rsp_value[31:0]); end
        handshake();
        checks++; if (hit_cnt !== 32'd2) begin
            failures++; $display("FAIL dual_hit_cnt: got %0d exp 2", hit_cnt); end
    endtask

    task automatic test_miss_out_of_order();
        int vr0;
        vr0 = val_rd_cnt;
        issue(24'h800001);
        checks++; if (hraddr0 !== 10'h009 || hraddr1 !== 10'h009) begin
            failures++; $display("FAIL miss_raddr: %h %h exp 009 009", hraddr0, hraddr1); end
        hack1 = 1'b1; hdata1 = mk(1'b1, 24'h800000, 10'h111);
        tick();
        hack1 = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin
            failures++; $display("FAIL miss_early_rsp: valid=%b exp 0", rsp_valid); end
        // Repeat ack1 with a matching bucket: must not replace the first capture.
        hack1 = 1'b1; hdata1 = mk(1'b1, 24'h800001, 10'h222);
        tick();
        hack1 = 1'b0;
        tick();
        hack0 = 1'b1; hdata0 = mk(1'b0, 24'h800001, 10'h333);
        tick();
        hack0 = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_value !== '0) begin
            failures++; $display("FAIL miss_rsp: valid=%b hit=%b value_nz=%b exp 1/0/0", rsp_valid, rsp_hit, |rsp_value); end
        checks++; if (val_rd_cnt !== vr0) begin
            failures++; $display("FAIL miss_no_value_rd: got %0d reads exp %0d", val_rd_cnt, vr0); end
        handshake();
        checks++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd2) begin
            failures++; $display("FAIL miss_cnt: miss=%0d hit=%0d exp 1/2", miss_cnt, hit_cnt); end
    endtask

    task automatic test_backpressure();
        int hr;
        issue(24'h000005);
        tick();
        ack_both(mk(1'b1, 24'h000005, 10'h055), mk(1'b0, 24'h000000, 10'h000));
        ack_value(VAL_C);
        hr = hash_rd_cnt;
        lkup_req = 1'b1;
        lkup_key = 24'h000003;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_value !== VAL_C || lkup_rdy !== 1'b0) begin
                failures++; $display("FAIL bp_hold[%0d]: valid=%b hit=%b rdy=%b value=%h", i, rsp_valid, rsp_hit, lkup_rdy, rsp_value[31:0]); end
        end
        handshake();
        checks++; if (lkup_rdy !== 1'b1 || rsp_valid !== 1'b0 || hash_rd_cnt !== hr || hrd0 !== 1'b0) begin
            failures++; $display("FAIL bp_after_hs: rdy=%b valid=%b rd=%b reads=%0d exp 1/0/0/%0d", lkup_rdy, rsp_valid, hrd0, hash_rd_cnt, hr); end
        checks++; if (hit_cnt !== 32'd3) begin
            failures++; $display("FAIL bp_hit_cnt: got %0d exp 3", hit_cnt); end
        tick();
        lkup_req = 1'b0;
        checks++; if (hrd0 !== 1'b1 || hraddr0 !== 10'h003 || hraddr1 !== 10'h00C) begin
            failures++; $display("FAIL bp_second_accept: rd=%b a0=%h a1=%h exp 1/003/00c", hrd0, hraddr0, hraddr1); end
        ack_both(mk(1'b0, 24'h000003, 10'h001), mk(1'b1, 24'h000004, 10'h002));
        checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0) begin
            failures++; $display("FAIL bp_second_rsp: valid=%b hit=%b exp 1/0", rsp_valid, rsp_hit); end
        handshake();
        checks++; if (miss_cnt !== 32'd2) begin
            failures++; $display("FAIL bp_miss_cnt: got %0d exp 2", miss_cnt); end
    endtask

    task automatic test_reset_mid();
        int vr0;
        issue(24'h000005);
        tick();
        hack0 = 1'b1; hdata0 = mk(1'b1, 24'h000005, 10'h077);
        tick();
        hack0 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (lkup_rdy !== 1'b1 || rsp_valid !== 1'b0 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            failures++; $display("FAIL rstmid_state: rdy=%b valid=%b hit=%0d miss=%0d exp 1/0/0/0", lkup_rdy, rsp_valid, hit_cnt, miss_cnt); end
        vr0 = val_rd_cnt;
        ack_both(mk(1'b1, 24'h000005, 10'h077), mk(1'b1, 24'h000005, 10'h078));
        tick();
        checks++; if (rsp_valid !== 1'b0 || lkup_rdy !== 1'b1 || val_rd_cnt !== vr0) begin
            failures++; $display("FAIL rstmid_stale_ack: valid=%b rdy=%b reads=%0d exp 0/1/%0d", rsp_valid, lkup_rdy, val_rd_cnt, vr0); end
        issue(24'h000005);
        tick();
        ack_both(mk(1'b0, 24'h000005, 10'h3FF), mk(1'b1, 24'h000005, 10'h0AB));
        checks++; if (vrd !== 1'b1 || vraddr !== 10'h0AB) begin
            failures++; $display("FAIL rstmid_t1_hit: rd=%b addr=%h exp 1/0ab", vrd, vraddr); end
        ack_value(VAL_C);
        checks++; if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_value !== VAL_C) begin
            failures++; $display("FAIL rstmid_rsp: valid=%b hit=%b value=%h", rsp_valid, rsp_hit, rsp_value[31:0]); end
        handshake();
        checks++; if (hit_cnt !== 32'd1) begin
            failures++; $display("FAIL rstmid_hit_cnt: got %0d exp 1", hit_cnt); end
    endtask

    task automatic test_saturation();
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.hit_cnt_q;
        tick();
        issue(24'h000005);
        tick();
        ack_both(mk(1'b1, 24'h000005, 10'h001), mk(1'b0, 24'h000000, 10'h000));
        ack_value(VAL_A);
        handshake();
        checks++; if (hit_cnt !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL sat_hit_cnt: got %h exp ffffffff", hit_cnt); end
        checks++; if (miss_cnt !== 32'd0) begin
            failures++; $display("FAIL sat_miss_cnt: got %0d exp 0", miss_cnt); end
    endtask

    initial begin
        rst = 1'b1; lkup_req = 1'b0; lkup_key = '0;
        hack0 = 1'b0; hack1 = 1'b0; hdata0 = '0; hdata1 = '0;
        vack = 1'b0; vdata = '0; rsp_rdy = 1'b0;
        test_reset();
        test_table0_hit();
        test_dual_match();
        test_miss_out_of_order();
        test_backpressure();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encap_tunnel_lookup.md
Name: encap_tunnel_lookup

Overview:
- Application-side reader for the tunnel hash and value memories: the initiator of the hash_table0/1 and value read ports.
- Accepts a tunnel key from the encap pipeline and computes two bucket indices.
- Reads both hash tables in parallel and compares the stored keys. On a hit it fetches the wide tunnel value record; on a miss it returns a miss flag.
- Sits between the encap header builder and the tunnel memory block. Maintains saturating hit/miss counters for PIO status.

Parameters:
- DEPTH_NBITS, 10, hash table index width (`TUNNEL_HASH_TABLE_DEPTH_NBITS).
- KEY_NBITS, 24, tunnel key width.
- VALUE_DEPTH_NBITS, 10, value table index width (`TUNNEL_VALUE_DEPTH_NBITS).
- BUCKET_NBITS, 1+KEY_NBITS+VALUE_DEPTH_NBITS (35), bucket layout {valid, key, value_ptr}, MSB first.
- VALUE_NBITS, 288, tunnel value record width (`TUNNEL_VALUE_NBITS).
- CNT_NBITS, 32, statistics counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset, declared through `RESET_SIG.
- lkup_req  in  1  lookup request valid.
- lkup_key  in  KEY_NBITS  key, sampled when lkup_req & lkup_rdy.
- lkup_rdy  out  1  high only in IDLE.
- tunnel_hash_table0_rd  out  1  single-cycle read pulse.
- tunnel_hash_table0_raddr  out  DEPTH_NBITS  h0.
- tunnel_hash_table1_rd  out  1  single-cycle read pulse.
- tunnel_hash_table1_raddr  out  DEPTH_NBITS  h1.
- tunnel_hash_table0_ack / tunnel_hash_table1_ack  in  1  each a one-cycle pulse with rdata valid.
- tunnel_hash_table0_rdata / tunnel_hash_table1_rdata  in  BUCKET_NBITS  bucket contents.
- tunnel_value_rd  out  1  single-cycle read pulse.
- tunnel_value_raddr  out  VALUE_DEPTH_NBITS  value pointer from the matching bucket.
- tunnel_value_ack  in  1  one-cycle pulse with value rdata.
- tunnel_value_rdata  in  VALUE_NBITS  value record.
- rsp_valid  out  1  result valid; held until rsp_rdy.
- rsp_rdy  in  1  consumer accepts the result.
- rsp_hit  out  1  1 = hit.
- rsp_value  out  VALUE_NBITS  value record on hit, 0 on miss.
- hit_cnt, miss_cnt  out  CNT_NBITS  saturating statistics counters.

Behaviour:
- Reset: state IDLE. All rd strobes, raddrs, rsp_valid, rsp_hit, rsp_value and both counters go to 0; lkup_rdy = 1 once out of reset.
- Hash functions:
  - h0 = key[9:0] ^ key[19:10] ^ {6'b0, key[23:20]}. Generalised: XOR-fold of key in DEPTH_NBITS chunks, last chunk zero-extended.
  - h1 = the same fold applied to the bit-reversed key.
- State machine IDLE -> HASH_WAIT -> (VAL_WAIT) -> RSP -> IDLE.
- IDLE:
  - On lkup_req, register the key.
  - Next cycle, assert both hash rd strobes for exactly one cycle with registered h0/h1.
  - Go to HASH_WAIT.
- HASH_WAIT:
  - Acks may arrive in any order, same cycle or different cycles, any latency.
  - Each ack latches its rdata and sets a got0/got1 flag.
  - When both flags are set (including a same-cycle second ack), evaluate:
    - m0 = b0.valid & b0.key == key; m1 likewise for b1.
    - m0 wins if both match.
    - Hit: pulse tunnel_value_rd one cycle with the winner's ptr, go to VAL_WAIT.
    - Miss: go to RSP with rsp_hit = 0 and rsp_value = 0.
- VAL_WAIT: on tunnel_value_ack, register rdata into rsp_value, set rsp_hit = 1, go to RSP.
- RSP:
  - rsp_valid = 1; outputs stable until rsp_rdy.
  - On the rsp_valid & rsp_rdy cycle: increment hit_cnt or miss_cnt (saturate at all-ones, no wrap), then go to IDLE.
  - lkup_rdy rises the following cycle.
- Latency: minimum from request accept to rsp_valid is 1 + hash ack latency + 1 (miss), plus value latency + 1 on a hit.
- Unexpected input:
  - Acks arriving in a state that does not expect them are ignored.
  - A duplicate ack for an already-set flag is ignored.
  - lkup_req while lkup_rdy = 0 is not accepted; the requester holds it.
- Mid-operation reset: return immediately to IDLE and drop the lookup. Memories are not cancelled; late acks arrive in IDLE and are ignored.
- Only one lookup is outstanding at a time.

Decomposition:
- Shared package (defines.vh entries): bucket field offsets (BKT_VALID_BIT, BKT_KEY_LSB, BKT_PTR_LSB), state encodings, default widths.
- One natural sub-module: tunnel_hash_fold (combinational, parameterised fold/reverse), instantiated twice for h0/h1.

Test Plan:
- Table0 hit:
  - Stimulus: key = 0x000005; acks return b0 = {1, 0x000005, ptr 0x123} and b1 = {0, ...}; value ack returns 0xABCD... .
  - Required: raddr0 = 0x005, raddr1 = 0x00A, value_raddr = 0x123, rsp_hit = 1 with that value, hit_cnt = 1.
- Dual match:
  - Stimulus: both buckets match key 0x000005, b0 ptr 0x010, b1 ptr 0x020.
  - Required: value_raddr = 0x010.
- Miss, acks out of order:
  - Stimulus: ack1 first, ack0 3 cycles later, both key mismatch.
  - Required: no tunnel_value_rd; rsp_hit = 0, rsp_value = 0, miss_cnt increments.
- Backpressure:
  - Stimulus: hold rsp_rdy = 0 for 5 cycles.
  - Required: rsp fields stable, lkup_rdy = 0, second lkup_req not accepted until the cycle after the handshake.
- Reset mid-operation:
  - Stimulus: assert rst in HASH_WAIT, release, then deliver a stale ack0.
  - Required: state IDLE, no rsp_valid, counters 0; a new lookup then completes correctly.
- Saturation:
  - Stimulus: preload hit_cnt to all-ones via force, then perform one more hit.
  - Required: hit_cnt stays 0xFFFFFFFF.
